// File: rtl/led_pio_scheduler.sv
// Sole Avalon-MM writer of the 8-bit LED PIO: round-robin between host writes and a prescaled auto-pattern engine.
// Latency: host request to strobe 1 cycle, tick to strobe 2 cycles; optional dropped-tick counter under LED_SCHED_DROPCNT_EN.
module led_pio_scheduler #(
    parameter int PRESCALE = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        h_req,
    input  logic [7:0]  h_data,
    output logic        h_grant,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic        busy,
    output logic [7:0]  pattern
`ifdef LED_SCHED_DROPCNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);

    typedef enum logic {IDLE, WR} state_t;

    typedef struct packed {
        logic       dir_right;
        logic [7:0] value;
    } auto_nxt_t;

    state_t     state;
    state_t     state_nxt;
    logic [CW-1:0] pre_cnt;
    logic       tick;
    logic       auto_pend;
    logic       auto_clr;
    logic       launch;
    logic       sel_host;
    logic       tie;
    logic       last_grant_host;
    logic       dir_right;
    logic       wr_host;
    logic [7:0] wr_val;
    auto_nxt_t  auto_nxt;

    function automatic auto_nxt_t next_auto(input logic [7:0] cur, input logic [1:0] md,
                                            input logic right);
        auto_nxt_t r;
        r.dir_right = right;
        r.value     = cur;
        case (md)
            2'b01: r.value = cur + 8'd1;
            2'b10: r.value = {cur[6:0], cur[7]};
            2'b11: begin
                if (!$onehot(cur)) begin
                    r.value     = 8'h01;
                    r.dir_right = 1'b0;
                end else if (!right) begin
                    if (cur == 8'h80) begin
                        r.value     = 8'h40;
                        r.dir_right = 1'b1;
                    end else begin
                        r.value = cur << 1;
                    end
                end else begin
                    if (cur == 8'h01) begin
                        r.value     = 8'h02;
                        r.dir_right = 1'b0;
                    end else begin
                        r.value = cur >> 1;
                    end
                end
            end
            default: r.value = cur;
        endcase
        return r;
    endfunction

    // Prescaler only runs while enabled; disabling parks it at zero.
    assign tick = enable && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (!enable || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Host wins when alone, or on a tie when the auto engine had the previous tie.
    assign tie      = h_req && auto_pend;
    assign sel_host = h_req && (!auto_pend || !last_grant_host);
    assign launch   = (state == IDLE) && (h_req || auto_pend);
    assign auto_clr = launch && !sel_host;
    assign auto_nxt = next_auto(pattern, mode, dir_right);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend <= 1'b0;
        end else begin
            auto_pend <= tick || (auto_pend && !auto_clr);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (h_req || auto_pend) state_nxt = WR;
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_val          <= 8'h00;
            wr_host         <= 1'b0;
            dir_right       <= 1'b0;
            last_grant_host <= 1'b0;
            pattern         <= 8'h00;
        end else begin
            if (launch) begin
                wr_host <= sel_host;
                wr_val  <= sel_host ? h_data : auto_nxt.value;
                if (!sel_host) dir_right <= auto_nxt.dir_right;
                if (tie) last_grant_host <= sel_host;
            end
            if (state == WR) pattern <= wr_val;
        end
    end

    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        busy         = 1'b0;
        h_grant      = 1'b0;
        if (state == WR) begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            busy         = 1'b1;
            h_grant      = wr_host;
        end
    end

    assign m_address   = 2'b00;
    assign m_writedata = {24'h000000, wr_val};

`ifdef LED_SCHED_DROPCNT_EN
    // A tick is lost only when the pending flag is neither consumed nor free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= 16'h0000;
        end else if (tick && auto_pend && !auto_clr && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
